// File: rtl/crossp_outq_if.sv
// Handshake/bus bundle for crossp_outq: credit issue side, result capture side,
// and the valid/ready output side plus status (count, sticky err).
interface crossp_outq_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             issue;
    logic             issue_ok;
    logic             i_valid;
    logic [WIDTH-1:0] i_x;
    logic [WIDTH-1:0] i_y;
    logic [WIDTH-1:0] i_z;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_x;
    logic [WIDTH-1:0] o_y;
    logic [WIDTH-1:0] o_z;
    logic [CW-1:0]    count;
    logic [1:0]       err;

    // upstream issuer + downstream consumer side
    modport master (
        output issue, i_valid, i_x, i_y, i_z, o_ready,
        input  issue_ok, o_valid, o_x, o_y, o_z, count, err
    );

    // the queue itself
    modport slave (
        input  issue, i_valid, i_x, i_y, i_z, o_ready,
        output issue_ok, o_valid, o_x, o_y, o_z, count, err
    );
endinterface

// File: rtl/crossp_outq.sv
// crossp_outq: credit-managed first-word-fall-through output queue behind the
// non-stallable crossp pipe. Credits guarantee every in-flight op has a slot,
// so results are never dropped in legal operation.
module crossp_outq #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset_l,
    crossp_outq_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    // inflight can exceed DEPTH when upstream violates credits; give headroom
    localparam int IW = CW + 2;

    logic [WIDTH-1:0] mem_x_q [DEPTH];
    logic [WIDTH-1:0] mem_y_q [DEPTH];
    logic [WIDTH-1:0] mem_z_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    inflight_q, inflight_d;
    logic [1:0]       err_q, err_d;
    logic             issue_ok_q, issue_ok_d;
    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_x_q, o_x_d;
    logic [WIDTH-1:0] o_y_q, o_y_d;
    logic [WIDTH-1:0] o_z_q, o_z_d;

    logic             rd_en, wr_en, full;
    logic [IW:0]      credit_sum;

    // next-state: pointers, occupancy, credits, sticky errors and the head register
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        rd_en      = (count_q != '0) && bus.o_ready;
        // a full queue still accepts a write when the head leaves the same cycle
        wr_en      = bus.i_valid && (!full || rd_en);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // issue and arrival together leave inflight unchanged; orphan arrival saturates at 0
        if (bus.issue && !bus.i_valid) begin
            if (inflight_q != '1) inflight_d = inflight_q + IW'(1);
        end else if (!bus.issue && bus.i_valid) begin
            if (inflight_q != '0) inflight_d = inflight_q - IW'(1);
        end

        err_d      = err_q;
        if (bus.issue && !issue_ok_q) err_d[0] = 1'b1;
        if (bus.i_valid && ((inflight_q == '0) || !wr_en)) err_d[1] = 1'b1;

        // credit registered from next state: no combinational path from issue/o_ready
        credit_sum = (IW+1)'(inflight_d) + (IW+1)'(count_d);
        issue_ok_d = (credit_sum < (IW+1)'(DEPTH));

        // head register: zero when empty, bypass the incoming word when it becomes head
        o_valid_d  = (count_d != '0);
        o_x_d      = '0;
        o_y_d      = '0;
        o_z_d      = '0;
        if (count_d != '0) begin
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                o_x_d = bus.i_x;
                o_y_d = bus.i_y;
                o_z_d = bus.i_z;
            end else begin
                o_x_d = mem_x_q[rd_ptr_d];
                o_y_d = mem_y_q[rd_ptr_d];
                o_z_d = mem_z_q[rd_ptr_d];
            end
        end
    end

    // control state and registered outputs
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= '0;
            issue_ok_q <= 1'b1;
            o_valid_q  <= 1'b0;
            o_x_q      <= '0;
            o_y_q      <= '0;
            o_z_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            issue_ok_q <= issue_ok_d;
            o_valid_q  <= o_valid_d;
            o_x_q      <= o_x_d;
            o_y_q      <= o_y_d;
            o_z_q      <= o_z_d;
        end
    end

    // storage array; contents are only observed through valid pointers, so no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_x_q[wr_ptr_q] <= bus.i_x;
            mem_y_q[wr_ptr_q] <= bus.i_y;
            mem_z_q[wr_ptr_q] <= bus.i_z;
        end
    end

    assign bus.issue_ok = issue_ok_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_x      = o_x_q;
    assign bus.o_y      = o_y_q;
    assign bus.o_z      = o_z_q;
    assign bus.count    = count_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_crossp_outq.sv
// Bench for crossp_outq: a LAT-cycle crossp delay line feeds the queue, a
// queue-based reference model tracks contents/credits/errors, and a negedge
// process compares every output every cycle.
module tb_crossp_outq;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int LAT   = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset_l = 1'b1;
    always #5 clk = ~clk;

    crossp_outq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    crossp_outq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .reset_l(reset_l), .bus(bus));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3*WIDTH-1:0] mq[$];
    int                 m_inf;
    logic [1:0]         m_err;
    int                 m_sz;
    bit                 m_rd, m_wr, m_ok;

    initial begin
        m_inf = 0;
        m_err = 2'b00;
        forever begin
            @(posedge clk or negedge reset_l);
            if (!reset_l) begin
                mq.delete();
                m_inf = 0;
                m_err = 2'b00;
            end else begin
                m_sz = mq.size();
                m_ok = (m_inf + m_sz) < DEPTH;
                m_rd = (m_sz > 0) && bus.o_ready;
                m_wr = bus.i_valid && ((m_sz < DEPTH) || m_rd);
                if (bus.issue && !m_ok) m_err[0] = 1'b1;
                if (bus.i_valid && ((m_inf == 0) || !m_wr)) m_err[1] = 1'b1;
                if (m_rd) void'(mq.pop_front());
                if (m_wr) mq.push_back({bus.i_x, bus.i_y, bus.i_z});
                if (bus.issue && !bus.i_valid) m_inf++;
                else if (!bus.issue && bus.i_valid && m_inf > 0) m_inf--;
            end
        end
    end

    // ---------------- compare process ----------------
    bit                 cmp_en = 1'b0;
    bit                 order_en = 1'b0;
    int                 exp_pop = 0;
    int                 n_pop = 0;
    int                 max_cnt = 0;
    bit                 ok_drop = 1'b0;
    logic [3*WIDTH-1:0] h;

    always @(negedge clk) begin
        if (cmp_en) begin
            h = (mq.size() != 0) ? mq[0] : '0;
            chk("o_valid",  bus.o_valid, mq.size() != 0);
            chk("o_x",      bus.o_x, h[3*WIDTH-1 -: WIDTH]);
            chk("o_y",      bus.o_y, h[2*WIDTH-1 -: WIDTH]);
            chk("o_z",      bus.o_z, h[WIDTH-1:0]);
            chk("count",    bus.count, mq.size());
            chk("issue_ok", bus.issue_ok, (m_inf + mq.size()) < DEPTH);
            chk("err",      bus.err, m_err);
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
            if (!bus.issue_ok) ok_drop = 1'b1;
            if (bus.o_valid && bus.o_ready && reset_l) begin
                n_pop++;
                if (order_en) begin
                    chk("pop_order", bus.o_x, exp_pop);
                    exp_pop++;
                end
            end
        end
    end

    // ---------------- crossp delay line + drivers ----------------
    bit pv[LAT];
    int pseq[LAT];
    int seq = 0;
    int n_iss = 0;

    task automatic drive(input bit want, input bit force_i, input bit rdy);
        bit iss;
        @(posedge clk);
        #1;
        bus.i_valid = pv[LAT-1];
        bus.i_x     = pv[LAT-1] ? pseq[LAT-1]     : 0;
        bus.i_y     = pv[LAT-1] ? 2 * pseq[LAT-1] : 0;
        bus.i_z     = pv[LAT-1] ? 3 * pseq[LAT-1] : 0;
        for (int k = LAT - 1; k > 0; k--) begin
            pv[k]   = pv[k-1];
            pseq[k] = pseq[k-1];
        end
        iss       = want && (bus.issue_ok || force_i);
        pv[0]     = iss;
        pseq[0]   = seq;
        if (iss) begin
            seq++;
            n_iss++;
        end
        bus.issue   = iss;
        bus.o_ready = rdy;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_l     = 1'b0;
        bus.issue   = 1'b0;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            pv[k]   = 1'b0;
            pseq[k] = 0;
        end
        seq     = 0;
        n_iss   = 0;
        n_pop   = 0;
        exp_pop = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_l = 1'b1;
        max_cnt = 0;
        ok_drop = 1'b0;
    endtask

    int first_block;

    initial begin
        bus.issue   = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_x     = '0;
        bus.i_y     = '0;
        bus.i_z     = '0;
        bus.o_ready = 1'b0;
        #1 reset_l = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_o_valid",  bus.o_valid, 1'b0);
        chk("rst_count",    bus.count, 0);
        chk("rst_issue_ok", bus.issue_ok, 1'b1);
        chk("rst_o_x",      bus.o_x, 0);

        // fill with o_ready low: credits stop issue after DEPTH ops
        do_reset();
        first_block = -1;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (!bus.issue_ok && first_block < 0) first_block = i;
        end
        chk("fill_issues", n_iss, 8);
        chk("fill_block_cycle", first_block, 8);
        chk("fill_count", bus.count, 8);
        chk("fill_err", bus.err, 2'b00);
        chk("fill_head", bus.o_x, 0);

        // full queue: read and write in the same cycle keeps count at DEPTH
        @(posedge clk);
        #1;
        bus.i_valid = 1'b1;
        bus.i_x     = 32'hA5;
        bus.i_y     = 32'hB6;
        bus.i_z     = 32'hC7;
        bus.o_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b0;
        chk("fullrw_count", bus.count, 8);
        chk("fullrw_head", bus.o_x, 1);
        repeat (12) drive(1'b0, 1'b0, 1'b1);
        chk("fullrw_drained", bus.count, 0);

        // back-to-back streaming: 100 ops in order, credits never run out
        do_reset();
        order_en = 1'b1;
        for (int i = 0; i < 400 && n_pop < 100; i++) drive(n_iss < 100, 1'b0, 1'b1);
        order_en = 1'b0;
        chk("stream_pops", n_pop, 100);
        chk("stream_max_cnt_le5", max_cnt <= 5, 1'b1);
        chk("stream_ok_never_drop", ok_drop, 1'b0);
        chk("stream_err", bus.err, 2'b00);

        // random back-pressure across several pointer wraps
        do_reset();
        order_en = 1'b1;
        for (int i = 0; i < 3000 && n_pop < 3 * DEPTH + 5; i++)
            drive(n_iss < 3 * DEPTH + 5, 1'b0, 1'($urandom_range(0, 1)));
        order_en = 1'b0;
        chk("wrap_pops", n_pop, 3 * DEPTH + 5);
        chk("wrap_err", bus.err, 2'b00);

        // orphan arrival, then issue without credit
        do_reset();
        @(posedge clk);
        #1;
        bus.i_valid = 1'b1;
        bus.i_x     = 32'h7;
        bus.i_y     = 32'he;
        bus.i_z     = 32'h15;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        chk("orphan_err", bus.err, 2'b10);
        chk("orphan_count", bus.count, 1);
        chk("orphan_head", bus.o_z, 32'h15);
        repeat (10) drive(1'b1, 1'b0, 1'b0);
        chk("orphan_issues", n_iss, 7);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("overissue_err", bus.err, 2'b11);
        repeat (20) drive(1'b0, 1'b0, 1'b1);

        // reset mid-operation with results still in flight
        do_reset();
        for (int i = 0; i < 30 && bus.count != 5; i++) drive(1'b1, 1'b0, 1'b0);
        chk("mid_count5", bus.count, 5);
        reset_l = 1'b0;
        #2;
        chk("midrst_o_valid",  bus.o_valid, 1'b0);
        chk("midrst_count",    bus.count, 0);
        chk("midrst_issue_ok", bus.issue_ok, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        reset_l = 1'b1;
        repeat (6) drive(1'b0, 1'b0, 1'b0);
        chk("late_err1", bus.err[1], 1'b1);
        chk("late_err0", bus.err[0], 1'b0);
        chk("late_count", bus.count, 2);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
